// File: rtl/rounding_pkg.sv
// rounding_pkg: shared defaults and state type for the rounding divider / interpolating upscaler pair
//   DIV_LOG2_DEF   log2 of the scale factor (and of beats per input sample)
//   OUT_WIDTH_DEF  width of the quantized sample
//   interp_state_e upscaler FSM states
package rounding_pkg;
    localparam int DIV_LOG2_DEF  = 3;
    localparam int OUT_WIDTH_DEF = 8;
    typedef enum logic {IDLE, RAMP} interp_state_e;
endpackage

// File: rtl/interp_upscaler.sv
// interp_upscaler: rebuilds an IN_WIDTH stream from OUT_WIDTH samples, 2^DIV_LOG2 beats per sample,
// linearly ramping from (prev<<DIV_LOG2) towards (cur<<DIV_LOG2).
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   clear    synchronous flush: abort ramp, zero history, blocks s_ready
//   s_valid / s_ready / s_data   quantized input sample stream
//   m_valid / m_ready / m_data   reconstructed output beat stream
module interp_upscaler
    import rounding_pkg::*;
#(
    parameter int DIV_LOG2  = DIV_LOG2_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [OUT_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IN_WIDTH-1:0]  m_data
);
    interp_state_e        state_q, state_d;
    logic [OUT_WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, base;
    logic [OUT_WIDTH:0]   delta_q, delta_d;
    logic [IN_WIDTH:0]    acc_q, acc_d;
    logic [DIV_LOG2-1:0]  phase_q, phase_d;
    logic                 last, accept;

    assign last    = (state_q == RAMP) && (&phase_q);
    assign accept  = s_valid && s_ready;
    // A sample taken on the last beat must ramp from cur, since prev only catches up at that edge.
    assign base    = (state_q == RAMP) ? cur_q : prev_q;
    assign m_valid = (state_q == RAMP);
    assign m_data  = acc_q[IN_WIDTH-1:0];

    always_comb begin
        s_ready = !clear && ((state_q == IDLE) || (last && m_ready));
        state_d = state_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        delta_d = delta_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        if (clear) begin
            state_d = IDLE;
            prev_d  = '0;
            phase_d = '0;
            acc_d   = '0;
        end else begin
            if ((state_q == RAMP) && m_ready) begin
                acc_d   = acc_q + {{DIV_LOG2{delta_q[OUT_WIDTH]}}, delta_q};
                phase_d = phase_q + 1'b1;
                if (last) begin
                    prev_d  = cur_q;
                    state_d = IDLE;
                end
            end
            if (accept) begin
                delta_d = {1'b0, s_data} - {1'b0, base};
                acc_d   = {1'b0, base, {DIV_LOG2{1'b0}}};
                cur_d   = s_data;
                phase_d = '0;
                state_d = RAMP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            cur_q   <= '0;
            delta_q <= '0;
            acc_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            delta_q <= delta_d;
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

    // Every beat lies between two non-negative endpoints, so the sign bit can never be set.
    assert property (@(posedge clk) disable iff (!rst) (state_q == RAMP) |-> !acc_q[IN_WIDTH]);
endmodule

// File: tb/tb_interp_upscaler.sv
// tb_interp_upscaler: scoreboard bench for interp_upscaler (DIV_LOG2=3, OUT_WIDTH=8)
module tb_interp_upscaler;
    logic        clk = 0, rst = 0, clear = 0, s_valid = 0, m_ready = 1;
    logic [7:0]  s_data = 0;
    logic        s_ready, m_valid;
    logic [10:0] m_data;
    int          checks = 0, errors = 0, prev_m = 0;
    int          sb[$];

    interp_upscaler dut (
        .clk(clk), .rst(rst), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected m_data=%0d, scoreboard empty", m_data);
            end else begin
                int exp_v;
                exp_v = sb.pop_front();
                if (m_data !== 11'(exp_v)) begin
                    errors++;
                    $display("FAIL beat: m_data=%0d expected %0d", m_data, exp_v);
                end
            end
        end
    end

    task automatic send(input int d);
        int n;
        s_valid = 1;
        s_data  = 8'(d);
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%b expected 1", s_ready);
        end
        for (int i = 0; i < 8; i++) sb.push_back((prev_m << 3) + i * (d - prev_m));
        prev_m = d;
        @(posedge clk);
        #1;
        s_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || m_valid) begin
            errors++;
            $display("FAIL drain: %0d beats pending, m_valid=%b expected 0/0", sb.size(), m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(posedge clk);
        #1;
        clear = 0;
        sb.delete();
        prev_m = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 2;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: m_valid=%b expected 0", m_valid); end
        if (m_data !== 11'd0) begin errors++; $display("FAIL reset_data: m_data=%0d expected 0", m_data); end
        rst = 1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: s_ready=%b expected 1", s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        send(8);
        drain();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: s_ready=%b expected 1", s_ready); end
        @(posedge clk);
        #1;
        send(0);
        drain();
        send(255);
        send(255);
        drain();
    endtask

    task automatic test_back_to_back();
        int v;
        v = 0;
        fork
            begin
                send(10);
                send(20);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!m_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 16; i++) begin
                    if (m_valid) v++;
                    @(negedge clk);
                end
                checks++;
                if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: m_valid=%b expected 0", m_valid); end
            end
        join
        checks++;
        if (v != 16) begin errors++; $display("FAIL b2b_bubbles: valid beats=%0d expected 16", v); end
        drain();
    endtask

    task automatic test_backpressure();
        pulse_clear();
        send(8);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_ready = 0;
        repeat (3) begin
            @(negedge clk);
            checks += 3;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: m_valid=%b expected 1", m_valid); end
            if (m_data !== 11'd16) begin errors++; $display("FAIL bp_hold: m_data=%0d expected 16", m_data); end
            if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: s_ready=%b expected 0", s_ready); end
            @(posedge clk);
            #1;
        end
        m_ready = 1;
        drain();
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        send(8);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 0;
        #1;
        checks += 2;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL async_valid: m_valid=%b expected 0", m_valid); end
        if (m_data !== 11'd0) begin errors++; $display("FAIL async_data: m_data=%0d expected 0", m_data); end
        sb.delete();
        prev_m = 0;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        send(8);
        drain();
    endtask

    task automatic test_clear();
        send(100);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        clear   = 1;
        s_valid = 1;
        s_data  = 8'd77;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: s_ready=%b expected 0", s_ready); end
        @(posedge clk);
        #1;
        clear   = 0;
        s_valid = 0;
        sb.delete();
        prev_m = 0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: m_valid=%b expected 0", m_valid); end
        @(posedge clk);
        #1;
        send(16);
        drain();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
